pll_reset_sequencer: RTL and testbench

//  Brings up the fabric PLL and sequences resets for its output-clock domains. Pulses the PLL

---
 rtl/pll_seq_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL bring-up and reset sequencer.
//  - pll_state_e : sequencer states
//  - DEF_*       : default timing constants for a 50 MHz reference clock
//  - LOSS_CNT_W  : width of the saturating lock-loss counter
//  - max_int     : helper used to size the shared cycle timer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } pll_state_e;

    localparam int DEF_NUM_DOMAINS         = 3;
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_RELEASE_GAP         = 8;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int LOSS_CNT_W              = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
//  clk     : destination clock
//  reset_n : asynchronous active-low reset, clears both stages to 0
//  d       : asynchronous input
//  q       : synchronised output, two cycles of latency
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and staggered domain-reset sequencer. Runs on the free-running
// reference clock: pulses the PLL reset, waits for a stable lock, releases the
// domain resets one by one (bit 0 first), then watches lock until it is lost or
// a soft restart is requested.
//  clk            : reference clock (also the PLL refclk)
//  reset_n        : asynchronous active-low reset
//  pll_rst        : PLL reset, active-high
//  pll_locked     : PLL lock, asynchronous
//  soft_reset_req : single-cycle request to restart the sequence
//  domain_rst_n   : active-low domain resets
//  ready          : all domains released and lock healthy
//  lock_fail      : MAX_RETRIES lock attempts timed out
//  loss_count     : lock-loss events since reset_n, saturating
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS         = DEF_NUM_DOMAINS,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int RELEASE_GAP         = DEF_RELEASE_GAP,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   pll_rst,
    input  logic                   pll_locked,
    input  logic                   soft_reset_req,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   lock_fail,
    output logic [LOSS_CNT_W-1:0]  loss_count
);

    localparam int REL_LAST = RELEASE_GAP * NUM_DOMAINS;
    localparam int TMAX     = max_int(max_int(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                      max_int(LOCK_TIMEOUT_CYCLES, REL_LAST));
    localparam int TW       = $clog2(TMAX + 1);
    localparam int RW       = $clog2(MAX_RETRIES + 1);

    pll_state_e             state, nxt;
    logic [TW-1:0]          timer;
    logic [RW-1:0]          retries, retries_nxt;
    logic                   lock_s;
    logic                   restart;   // soft request inside RESET_PLL: re-enter it
    logic                   loss;      // lock lost while domains were (being) released

    logic                   pll_rst_d, ready_d, lock_fail_d;
    logic [NUM_DOMAINS-1:0] dom_d;
    logic [LOSS_CNT_W-1:0]  loss_d;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lock_s)
    );

    // State, retry counter and shared timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RESET_PLL;
            retries <= '0;
            timer   <= '0;
        end else begin
            state   <= nxt;
            retries <= retries_nxt;
            if (nxt != state || restart)
                timer <= '0;
            else if (timer != TW'(TMAX))
                timer <= timer + TW'(1);
        end
    end

    // Next state
    always_comb begin
        nxt         = state;
        restart     = 1'b0;
        loss        = 1'b0;
        retries_nxt = retries;
        case (state)
            RESET_PLL: begin
                if (soft_reset_req)
                    restart = 1'b1;
                else if (timer == TW'(PLL_RST_CYCLES - 1))
                    nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (soft_reset_req)
                    nxt = RESET_PLL;
                else if (lock_s)
                    nxt = STABLE;
                else if (timer == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retries_nxt = retries + RW'(1);
                    nxt = (retries_nxt == RW'(MAX_RETRIES)) ? FAIL : RESET_PLL;
                end
            end
            STABLE: begin
                // A dropout before release is just another wait, not a loss event
                if (soft_reset_req)
                    nxt = RESET_PLL;
                else if (!lock_s)
                    nxt = WAIT_LOCK;
                else if (timer == TW'(LOCK_STABLE_CYCLES - 1))
                    nxt = RELEASE;
            end
            RELEASE, RUN: begin
                // Lock loss takes precedence so a coincident soft request still counts it
                if (!lock_s) begin
                    nxt  = RESET_PLL;
                    loss = 1'b1;
                end else if (soft_reset_req)
                    nxt = RESET_PLL;
                else if (state == RELEASE && timer == TW'(REL_LAST)) begin
                    nxt         = RUN;
                    retries_nxt = '0;
                end
            end
            FAIL: begin
                if (soft_reset_req) begin
                    nxt         = RESET_PLL;
                    retries_nxt = '0;
                end
            end
            default: nxt = RESET_PLL;
        endcase
    end

    // Output values for the next cycle, decoded from the next state
    always_comb begin
        pll_rst_d   = (nxt == RESET_PLL) || (nxt == FAIL);
        ready_d     = (nxt == RUN);
        lock_fail_d = (nxt == FAIL);
        dom_d       = '0;
        if (nxt == RUN)
            dom_d = '1;
        else if (nxt == RELEASE && state == RELEASE) begin
            // Released bits are sticky; bit k rises when the timer reaches GAP*(k+1)
            for (int k = 0; k < NUM_DOMAINS; k++)
                dom_d[k] = domain_rst_n[k] | ((int'(timer) + 1) == RELEASE_GAP * (k + 1));
        end
        loss_d = loss_count;
        if (loss && loss_count != '1)
            loss_d = loss_count + LOSS_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            lock_fail    <= 1'b0;
            loss_count   <= '0;
        end else begin
            pll_rst      <= pll_rst_d;
            domain_rst_n <= dom_d;
            ready        <= ready_d;
            lock_fail    <= lock_fail_d;
            loss_count   <= loss_d;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer. Expected edges are derived from
// the sequencing rules as arithmetic on a cycle index: pll_rst falls PRC cycles
// after it rises, release starts LSC+3 cycles after pll_locked last rose (LSC+1
// after WAIT_LOCK entry if lock never dropped), domain k rises GAP*(k+1) later,
// ready one cycle after the last release.
module tb_pll_reset_sequencer;

    localparam int ND  = 3;
    localparam int PRC = 4;
    localparam int LSC = 8;
    localparam int LTO = 64;
    localparam int GAP = 2;
    localparam int MR  = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pll_rst;
    logic          pll_locked;
    logic          soft_reset_req;
    logic [ND-1:0] domain_rst_n;
    logic          ready;
    logic          lock_fail;
    logic [7:0]    loss_count;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int exp_loss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pll_reset_sequencer #(
        .NUM_DOMAINS(ND), .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC),
        .LOCK_TIMEOUT_CYCLES(LTO), .RELEASE_GAP(GAP), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_rst(pll_rst), .pll_locked(pll_locked),
        .soft_reset_req(soft_reset_req), .domain_rst_n(domain_rst_n), .ready(ready),
        .lock_fail(lock_fail), .loss_count(loss_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    endtask

    // Advance to the falling edge following posedge number c
    task automatic goto(input int c);
        if (cyc > c) check("schedule", cyc, c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dom"},   32'(domain_rst_n), 0);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_prst"},  32'(pll_rst), 1);
    endtask

    // One bring-up starting from a pll_rst rise at edge rst_rise
    task automatic bring_up(input int rst_rise, input int dly, input int glitch, input bit held);
        int f, n, r, rel;
        f = rst_rise + PRC;
        goto(f - 1); check("prst_hold", 32'(pll_rst), 1);
        goto(f);     check("prst_fall", 32'(pll_rst), 0);
        if (held) rel = f + 1 + LSC;
        else begin
            goto(f + dly); n = cyc; pll_locked = 1'b1; r = n;
            if (glitch > 0) begin
                goto(n + glitch);     pll_locked = 1'b0;
                goto(n + glitch + 1); pll_locked = 1'b1;
                r = n + glitch + 1;
            end
            rel = r + 3 + LSC;
        end
        for (int k = 0; k < ND; k++) begin
            goto(rel + GAP * (k + 1) - 1); check("dom_pre",  32'(domain_rst_n), (1 << k) - 1);
            goto(rel + GAP * (k + 1));     check("dom_post", 32'(domain_rst_n), (1 << (k + 1)) - 1);
        end
        check("ready_pre", 32'(ready), 0);
        goto(rel + GAP * ND + 1);
        check("ready", 32'(ready), 1);
        check("loss_cnt", 32'(loss_count), exp_loss);
        check("lock_fail_run", 32'(lock_fail), 0);
        check("prst_run", 32'(pll_rst), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int n, m, f1, f2, f, rel;
        reset_n = 1'b0; pll_locked = 1'b0; soft_reset_req = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check_idle("rst");
        check("rst_lock_fail", 32'(lock_fail), 0);
        check("rst_loss", 32'(loss_count), 0);

        // Nominal bring-up, lock 10 cycles after pll_rst falls
        n = cyc; reset_n = 1'b1;
        bring_up(n, 10, 0, 0);

        // Soft request alone in RUN: no loss counted, lock still held
        n = cyc; soft_reset_req = 1'b1;
        goto(n + 1); soft_reset_req = 1'b0;
        check_idle("soft");
        check("soft_loss", 32'(loss_count), exp_loss);
        bring_up(n + 1, 0, 0, 1);

        // Lock loss during RELEASE after domain 0 is out
        n = cyc; soft_reset_req = 1'b1;
        goto(n + 1); soft_reset_req = 1'b0;
        f = n + 1 + PRC; rel = f + 1 + LSC;
        goto(rel + 1); pll_locked = 1'b0;
        goto(rel + 3); check("rel_loss_pre", 32'(domain_rst_n), 1);
        goto(rel + 4); check_idle("rel_loss");
        exp_loss++;
        check("rel_loss_cnt", 32'(loss_count), exp_loss);

        // Lock glitch in STABLE: no release, no loss, sequence restarts from relock
        bring_up(rel + 4, $urandom_range(0, 20), 5, 0);

        // One timeout, then lock on the second attempt
        n = cyc; soft_reset_req = 1'b1; pll_locked = 1'b0;
        goto(n + 1); soft_reset_req = 1'b0;
        f1 = n + 1 + PRC;
        goto(f1);           check("to1_fall", 32'(pll_rst), 0);
        goto(f1 + LTO - 1); check("to1_wait", 32'(pll_rst), 0);
        goto(f1 + LTO);     check("to1_retry", 32'(pll_rst), 1);
        check("to1_nofail", 32'(lock_fail), 0);
        bring_up(f1 + LTO, $urandom_range(0, 20), 0, 0);

        // Two timeouts -> FAIL, then soft request recovers
        n = cyc; soft_reset_req = 1'b1; pll_locked = 1'b0;
        goto(n + 1); soft_reset_req = 1'b0;
        f1 = n + 1 + PRC; f2 = f1 + LTO + PRC;
        goto(f1 + LTO); check("to2_retry", 32'(pll_rst), 1);
        goto(f2);       check("to2_fall", 32'(pll_rst), 0);
        goto(f2 + LTO - 1);
        check("to2_prefail", 32'(lock_fail), 0);
        check("to2_prefail_prst", 32'(pll_rst), 0);
        goto(f2 + LTO);
        check("fail", 32'(lock_fail), 1);
        check_idle("fail");
        goto(cyc + $urandom_range(1, 20));
        check("fail_hold", 32'(lock_fail), 1);
        m = cyc; soft_reset_req = 1'b1;
        goto(m + 1); soft_reset_req = 1'b0;
        check("fail_clear", 32'(lock_fail), 0);
        check("fail_clear_prst", 32'(pll_rst), 1);
        bring_up(m + 1, $urandom_range(0, 20), 0, 0);

        // Soft request coincident with synchronised lock loss: counted once
        n = cyc; pll_locked = 1'b0;
        goto(n + 2); soft_reset_req = 1'b1;
        check("coinc_pre", 32'(domain_rst_n), 7);
        goto(n + 3); soft_reset_req = 1'b0;
        check_idle("coinc");
        exp_loss++;
        check("coinc_loss", 32'(loss_count), exp_loss);
        bring_up(n + 3, $urandom_range(0, 20), 0, 0);

        // Repeated lock loss in RUN until the counter saturates
        for (int i = 0; i < 256; i++) begin
            goto(cyc + $urandom_range(0, 5));
            n = cyc; pll_locked = 1'b0;
            goto(n + 2); check("run_loss_pre", 32'(ready), 1);
            goto(n + 3); check_idle("run_loss");
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            check("run_loss_cnt", 32'(loss_count), exp_loss);
            bring_up(n + 3, $urandom_range(0, 20),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, LSC - 1) : 0, 0);
        end
        check("loss_sat", 32'(loss_count), 255);

        // reset_n mid-RELEASE with domain 0 released
        n = cyc; soft_reset_req = 1'b1;
        goto(n + 1); soft_reset_req = 1'b0;
        f = n + 1 + PRC; rel = f + 1 + LSC;
        goto(rel + GAP); check("mid_rel", 32'(domain_rst_n), 1);
        #1 reset_n = 1'b0; pll_locked = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_loss", 32'(loss_count), 0);
        check("async_rst_fail", 32'(lock_fail), 0);
        exp_loss = 0;
        @(negedge clk);
        n = cyc; reset_n = 1'b1;
        bring_up(n, $urandom_range(0, 20), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
